// File: rtl/delay_line_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : delay_line_arbiter_pkg
// Purpose : Shared default configuration, tag type and clog2 helper for the
//           delay-line arbiter and its tag pipe.
// Revision: 1.0 - initial release
// ============================================================================
package delay_line_arbiter_pkg;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WDATA   = 8;
    localparam int DEF_LATENCY = 4;
    localparam int DEF_MAXOUT  = 2;

    localparam int ID_W  = clog2(DEF_NREQ);
    localparam int CNT_W = clog2(DEF_MAXOUT + 1);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/delay_line_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : delay_line_tag_pipe
// Purpose : LATENCY-deep shift register of {valid, id} tags that mirrors the
//           external delay line so the tail lines up with LINE_OUT.
// Revision: 1.0 - initial release
// ============================================================================
module delay_line_tag_pipe
    import delay_line_arbiter_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int TAG_W   = $bits(tag_t)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    logic [TAG_W-1:0] pipe_q [LATENCY];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int k = 1; k < LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign tag_o = pipe_q[LATENCY-1];

    always_comb begin
        busy_o = 1'b0;
        for (int k = 0; k < LATENCY; k++) busy_o = busy_o | pipe_q[k][TAG_W-1];
    end

endmodule
`default_nettype wire

// File: rtl/delay_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : delay_line_arbiter
// Purpose : Round-robin sharing of one fixed-latency delay line between NREQ
//           requesters with per-requester in-flight caps. Optional macro
//           DELAY_ARB_PRIO_EN adds a PRIO input giving requester 0 precedence.
// Revision: 1.0 - initial release
// ============================================================================
module delay_line_arbiter
    import delay_line_arbiter_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WDATA   = DEF_WDATA,
    parameter int LATENCY = DEF_LATENCY,
    parameter int MAXOUT  = DEF_MAXOUT
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NREQ-1:0]       REQ_VALID,
    input  logic [NREQ*WDATA-1:0] REQ_DATA,
`ifdef DELAY_ARB_PRIO_EN
    input  logic                  PRIO,
`endif
    output logic [NREQ-1:0]       REQ_READY,
    output logic [WDATA-1:0]      LINE_IN,
    input  logic [WDATA-1:0]      LINE_OUT,
    output logic [NREQ-1:0]       RSP_VALID,
    output logic [WDATA-1:0]      RSP_DATA,
    output logic                  BUSY
);

    localparam int ID_BITS  = clog2(NREQ);
    localparam int CNT_BITS = clog2(MAXOUT + 1);
    localparam int PW       = ID_BITS + 1;

    typedef struct packed {
        logic               valid;
        logic [ID_BITS-1:0] id;
    } line_tag_t;

    logic [ID_BITS-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]    eligible, grant, rsp_hit;
    logic [ID_BITS-1:0] grant_idx;
    logic               grant_any, prio_win;
    logic [PW-1:0]      cand, ptr_inc;
    line_tag_t          tag_in, tag_out;

    // A response returning this cycle frees its slot for a same-cycle grant,
    // so a lone requester sustains MAXOUT accepts per LATENCY cycles.
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [CNT_BITS-1:0] cnt_q, cnt_d;

        assign rsp_hit[i]  = tag_out.valid && (tag_out.id == ID_BITS'(i));
        assign eligible[i] = REQ_VALID[i] && ((cnt_q < CNT_BITS'(MAXOUT)) || rsp_hit[i]);

        always_comb begin
            cnt_d = cnt_q;
            if (grant[i] && !rsp_hit[i])      cnt_d = cnt_q + CNT_BITS'(1);
            else if (!grant[i] && rsp_hit[i]) cnt_d = cnt_q - CNT_BITS'(1);
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                assert (!(grant[i] && !rsp_hit[i] && cnt_q == CNT_BITS'(MAXOUT)));
                assert (!(rsp_hit[i] && !grant[i] && cnt_q == '0));
            end
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        prio_win  = 1'b0;
        cand      = '0;
`ifdef DELAY_ARB_PRIO_EN
        if (PRIO && eligible[0]) begin
            grant_any = 1'b1;
            prio_win  = 1'b1;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + PW'(k);
            if (cand >= PW'(NREQ)) cand = cand - PW'(NREQ);
            if (!grant_any && eligible[cand[ID_BITS-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[ID_BITS-1:0];
            end
        end
        if (!RST_N) grant_any = 1'b0;
    end

    always_comb begin
        grant   = grant_any ? (NREQ'(1) << grant_idx) : '0;
        LINE_IN = grant_any ? REQ_DATA[grant_idx*WDATA +: WDATA] : '0;
        ptr_inc = {1'b0, grant_idx} + PW'(1);
        ptr_d   = ptr_q;
        if (grant_any && !prio_win)
            ptr_d = (ptr_inc == PW'(NREQ)) ? '0 : ptr_inc[ID_BITS-1:0];
        tag_in.valid = grant_any;
        tag_in.id    = grant_any ? grant_idx : '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    delay_line_tag_pipe #(
        .LATENCY (LATENCY),
        .TAG_W   ($bits(line_tag_t))
    ) u_tag_pipe (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .tag_i  (tag_in),
        .tag_o  (tag_out),
        .busy_o (BUSY)
    );

    assign REQ_READY = grant;
    assign RSP_VALID = rsp_hit;
    assign RSP_DATA  = LINE_OUT;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_delay_line_arbiter
// Purpose : Scoreboard bench driving two arbiters (latency 4 and latency 1)
//           from shared stimulus, each with its own modelled delay line.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_delay_line_arbiter;

    localparam int NREQ   = 4;
    localparam int WDATA  = 8;
    localparam int MAXOUT = 2;
    localparam int LAT0   = 4;
    localparam int LAT1   = 1;

    typedef struct {
        int               due;
        int               id;
        logic [WDATA-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WDATA-1:0] req_data  = '0;
`ifdef DELAY_ARB_PRIO_EN
    logic prio = 1'b0;
`endif

    logic [NREQ-1:0]  ready     [2];
    logic [WDATA-1:0] line_in   [2];
    logic [WDATA-1:0] line_out  [2];
    logic [NREQ-1:0]  rsp_valid [2];
    logic [WDATA-1:0] rsp_data  [2];
    logic             busy      [2];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q [2][$];
    int   mcnt  [2][NREQ];
    int   mptr  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    delay_line_arbiter #(.NREQ(NREQ), .WDATA(WDATA), .LATENCY(LAT0), .MAXOUT(MAXOUT)) dut0 (
        .CLK(clk), .RST_N(rst_n), .REQ_VALID(req_valid), .REQ_DATA(req_data),
`ifdef DELAY_ARB_PRIO_EN
        .PRIO(prio),
`endif
        .REQ_READY(ready[0]), .LINE_IN(line_in[0]), .LINE_OUT(line_out[0]),
        .RSP_VALID(rsp_valid[0]), .RSP_DATA(rsp_data[0]), .BUSY(busy[0]));

    delay_line_arbiter #(.NREQ(NREQ), .WDATA(WDATA), .LATENCY(LAT1), .MAXOUT(MAXOUT)) dut1 (
        .CLK(clk), .RST_N(rst_n), .REQ_VALID(req_valid), .REQ_DATA(req_data),
`ifdef DELAY_ARB_PRIO_EN
        .PRIO(prio),
`endif
        .REQ_READY(ready[1]), .LINE_IN(line_in[1]), .LINE_OUT(line_out[1]),
        .RSP_VALID(rsp_valid[1]), .RSP_DATA(rsp_data[1]), .BUSY(busy[1]));

    // External delay lines: never reset, so stale words survive a reset.
    logic [WDATA-1:0] dl0 [LAT0];
    logic [WDATA-1:0] dl1;
    always @(posedge clk) begin
        dl0[0] <= line_in[0];
        for (int k = 1; k < LAT0; k++) dl0[k] <= dl0[k-1];
        dl1 <= line_in[1];
    end
    assign line_out[0] = dl0[LAT0-1];
    assign line_out[1] = dl1;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    function automatic bit elig(input int d, input int i, input int rsp_id);
        int inflight;
        inflight = mcnt[d][i] - ((rsp_id == i) ? 1 : 0);
        return (req_valid[i] === 1'b1) && (inflight < MAXOUT);
    endfunction

    task automatic model_step(input int d);
        int lat, rsp_id, g, idx;
        bit pw;
        logic [NREQ-1:0]  exp_rdy;
        logic [WDATA-1:0] exp_li;
        exp_t e;
        lat = (d == 0) ? LAT0 : LAT1;
        if (rst_n !== 1'b1) begin
            exp_q[d].delete();
            mptr[d] = 0;
            for (int i = 0; i < NREQ; i++) mcnt[d][i] = 0;
            chk("ready_in_reset", d, 32'(ready[d]), 0);
            chk("line_in_reset", d, 32'(line_in[d]), 0);
            chk("busy_in_reset", d, 32'(busy[d]), 0);
            return;
        end
        rsp_id = -1;
        if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) rsp_id = exp_q[d][0].id;
        chk("busy", d, 32'(busy[d]), (exp_q[d].size() > 0) ? 1 : 0);
        g  = -1;
        pw = 1'b0;
`ifdef DELAY_ARB_PRIO_EN
        if (prio === 1'b1 && elig(d, 0, rsp_id)) begin
            g  = 0;
            pw = 1'b1;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr[d] + k) % NREQ;
            if (g < 0 && elig(d, idx, rsp_id)) g = idx;
        end
        exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
        exp_li  = (g >= 0) ? req_data[g*WDATA +: WDATA] : '0;
        chk("grant", d, 32'(ready[d]), 32'(exp_rdy));
        chk("line_in", d, 32'(line_in[d]), 32'(exp_li));
        if (g >= 0) begin
            e.due  = cyc + lat;
            e.id   = g;
            e.data = exp_li;
            exp_q[d].push_back(e);
            mcnt[d][g]++;
            if (!pw) mptr[d] = (g + 1) % NREQ;
        end
        if (rsp_id >= 0) mcnt[d][rsp_id]--;
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Monitor: retires expected responses exactly on their due cycle.
    always @(negedge clk) begin
        exp_t e;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
                e = exp_q[d].pop_front();
                chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(1 << e.id));
                chk("rsp_data", d, 32'(rsp_data[d]), 32'(e.data));
            end else begin
                chk("rsp_idle", d, 32'(rsp_valid[d]), 0);
            end
        end
    end

    task automatic drive(input logic [NREQ-1:0] v, input bit rnd, input logic r);
        @(posedge clk);
        #1;
        rst_n     = r;
        req_valid = v;
        for (int i = 0; i < NREQ; i++)
            req_data[i*WDATA +: WDATA] = rnd ? WDATA'($urandom) : WDATA'(16 + i);
`ifdef DELAY_ARB_PRIO_EN
        prio = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive('1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) drive(4'b0100, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive('0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive('1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) drive('1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive('0, 1'b0, 1'b1);
        drive('1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) drive(4'b0010, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++)
            drive(NREQ'($urandom), 1'b1, ($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0);
        for (int i = 0; i < 10; i++) drive('0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
